// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks incrementing data and frame lengths, counting frames and errors per run.
// Optional tready throttling is enabled by defining AXIS_CHK_THROTTLE_EN.
module axis_stream_checker #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int TP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  input  logic [CW-1:0] frame_len,
  input  logic [CW-1:0] num_frames,
  input  logic [TP-1:0] thr_pattern,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] data_err_cnt,
  output logic [CW-1:0] len_err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX = '1;

  state_t        state, state_nxt;
  logic          tready_q, ready_nxt;
  logic          launch, xfer, last_frame;
  logic [DW-1:0] exp;
  logic [CW-1:0] beat_cnt, len_q, num_q;

  assign launch     = start && (state != RUN);
  assign xfer       = s_tvalid && tready_q && (state == RUN);
  assign last_frame = (frame_cnt + ONE) == num_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (xfer && s_tlast && last_frame) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    s_tready = tready_q;
  end

`ifdef AXIS_CHK_THROTTLE_EN
  // Rotate register: tready in RUN follows its MSB; an all-zero pattern would stall forever.
  logic [TP-1:0] rot, rot_nxt;

  always_comb begin
    rot_nxt = rot;
    if (launch)             rot_nxt = (thr_pattern == '0) ? '1 : thr_pattern;
    else if (state == RUN)  rot_nxt = {rot[TP-2:0], rot[TP-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rot <= '0;
    else     rot <= rot_nxt;
  end

  assign ready_nxt = (state_nxt == RUN) && rot_nxt[TP-1];
`else
  logic unused_thr;
  assign unused_thr = ^thr_pattern;
  assign ready_nxt  = (state_nxt == RUN);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q     <= 1'b0;
      exp          <= '0;
      beat_cnt     <= '0;
      len_q        <= '0;
      num_q        <= '0;
      frame_cnt    <= '0;
      data_err_cnt <= '0;
      len_err_cnt  <= '0;
    end else begin
      tready_q <= ready_nxt;
      if (launch) begin
        exp          <= seed;
        len_q        <= (frame_len == '0) ? ONE : frame_len;
        num_q        <= (num_frames == '0) ? ONE : num_frames;
        beat_cnt     <= '0;
        frame_cnt    <= '0;
        data_err_cnt <= '0;
        len_err_cnt  <= '0;
      end else if (xfer) begin
        exp <= exp + 1'b1;
        if (s_tdata != exp && data_err_cnt != MAX)
          data_err_cnt <= data_err_cnt + ONE;
        if (s_tlast) begin
          // Length is judged only at tlast, so a missing tlast costs one error, not many.
          if ((beat_cnt + ONE) != len_q && len_err_cnt != MAX)
            len_err_cnt <= len_err_cnt + ONE;
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + ONE;
        end else if (beat_cnt != MAX) begin
          beat_cnt <= beat_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed self-checking bench for axis_stream_checker.
module tb_axis_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] frame_len = '0;
  logic [15:0] num_frames = '0;
  logic [7:0]  thr_pattern = '0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready, busy, done;
  logic [15:0] frame_cnt, data_err_cnt, len_err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  axis_stream_checker #(.DW(16), .CW(16), .TP(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .frame_len(frame_len),
    .num_frames(num_frames), .thr_pattern(thr_pattern), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .busy(busy),
    .done(done), .frame_cnt(frame_cnt), .data_err_cnt(data_err_cnt),
    .len_err_cnt(len_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [15:0] sd, input logic [15:0] len,
                           input logic [15:0] num, input logic [7:0] pat);
    seed = sd; frame_len = len; num_frames = num; thr_pattern = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int   n = 0;
    logic acc = 1'b0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!acc && n < 100) begin
      acc = s_tready;
      tick();
      n++; cyc++;
    end
    if (!acc) check("beat_timeout", 32'(acc), 32'd1);
  endtask

  task automatic stop_stream();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic check_end(input string tag, input int fr, input int de, input int le);
    check({tag, "_frames"}, 32'(frame_cnt), 32'(fr));
    check({tag, "_data_err"}, 32'(data_err_cnt), 32'(de));
    check({tag, "_len_err"}, 32'(len_err_cnt), 32'(le));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_tready"}, 32'(s_tready), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_tready", 32'(s_tready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frames", 32'(frame_cnt), 0);
    rst = 1'b0;
    tick();

    // 1: clean 3x4 run
    start_run(16'd100, 16'd4, 16'd3, 8'h00);
    check("t1_busy", 32'(busy), 1);
    check("t1_tready", 32'(s_tready), 1);
    for (int i = 0; i < 12; i++) send_beat(16'(100 + i), (i % 4) == 3);
    stop_stream();
    check_end("t1", 3, 0, 0);
    check("t1_busy_end", 32'(busy), 0);
    s_tvalid = 1'b1; s_tdata = 16'd5;
    repeat (3) tick();
    stop_stream();
    check("t1_no_accept_done", 32'(frame_cnt), 3);

    // 2: one corrupted beat; restart from DONE clears counters on entry
    start_run(16'd100, 16'd4, 16'd3, 8'h00);
    check("t2_clear_frames", 32'(frame_cnt), 0);
    for (int i = 0; i < 12; i++) begin
      send_beat((i == 5) ? 16'd0 : 16'(100 + i), (i % 4) == 3);
      if (i == 5) check("t2_err_latency", 32'(data_err_cnt), 1);
    end
    stop_stream();
    check_end("t2", 3, 1, 0);

    // 3: short first frame
    start_run(16'd7, 16'd4, 16'd2, 8'h00);
    for (int i = 0; i < 7; i++) send_beat(16'(7 + i), (i == 2) || (i == 6));
    stop_stream();
    check_end("t3", 2, 0, 1);

    // 3b: missing tlast at frame_len-1 counted once when tlast arrives
    start_run(16'd0, 16'd2, 16'd1, 8'h00);
    for (int i = 0; i < 3; i++) send_beat(16'(i), i == 2);
    stop_stream();
    check_end("t3b", 1, 0, 1);

    // 4: reset mid-run, then a clean run with a start pulse ignored during RUN
    start_run(16'd50, 16'd4, 16'd3, 8'h00);
    for (int i = 0; i < 5; i++) send_beat(16'(50 + i), (i % 4) == 3);
    stop_stream();
    rst = 1'b1;
    tick();
    check("t4_rst_frames", 32'(frame_cnt), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_tready", 32'(s_tready), 0);
    rst = 1'b0;
    tick();
    start_run(16'd0, 16'd4, 16'd3, 8'h00);
    for (int i = 0; i < 12; i++) begin
      send_beat(16'(i), (i % 4) == 3);
      if (i == 5) begin
        stop_stream();
        start_run(16'd999, 16'd1, 16'd1, 8'h00);
        check("t4_start_ignored", 32'(frame_cnt), 1);
      end
    end
    stop_stream();
    check_end("t4", 3, 0, 0);

    // 5: continuous valid over a 1x16 frame; throttle stretches it
    start_run(16'd0, 16'd16, 16'd1, 8'hA0);
    cyc = 0;
    for (int i = 0; i < 16; i++) send_beat(16'(i), i == 15);
    stop_stream();
    check_end("t5", 1, 0, 0);
`ifdef AXIS_CHK_THROTTLE_EN
    check("t5_cycles", 32'(cyc), 32'd59);
`else
    check("t5_cycles", 32'(cyc), 32'd16);
`endif

    // 6: long single frame with data wrap
    start_run(16'hFF00, 16'd3000, 16'd1, 8'h00);
    for (int i = 0; i < 3000; i++) send_beat(16'(16'hFF00 + i), i == 2999);
    stop_stream();
    check_end("t6", 1, 0, 0);

    // 0 for length and count behaves as 1
    start_run(16'd3, 16'd0, 16'd0, 8'h00);
    send_beat(16'd3, 1'b1);
    stop_stream();
    check_end("t7", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
